// File: rtl/diffuser_scheduler.sv
// rtl/diffuser_scheduler.sv - scent pump spray/pause sequencer with min:sec countdown
// Every output is registered, and its next value comes from the next FSM state.
module diffuser_scheduler #(
  parameter int TICKS_PER_SEC = 1_000_000,
  parameter int SEC_PER_MIN   = 60,
  parameter int SPRAY_SEC     = 5,
  parameter int PAUSE_SEC     = 25,
  parameter int TIMER0_MIN    = 30,
  parameter int TIMER1_MIN    = 60,
  parameter int TIMER2_MIN    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] scent_sel,
  input  logic [1:0] timer_sel,
  output logic [2:0] pump_en,
  output logic       running,
  output logic       done,
  output logic [6:0] remain_min,
  output logic [5:0] remain_sec
);

  localparam int PRE_W  = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PH_MAX = (SPRAY_SEC > PAUSE_SEC) ? SPRAY_SEC : PAUSE_SEC;
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PH_W-1:0]  SPRAY_LAST = PH_W'(SPRAY_SEC - 1);
  localparam logic [PH_W-1:0]  PAUSE_LAST = PH_W'(PAUSE_SEC - 1);
  localparam logic [5:0]       SEC_TOP    = 6'(SEC_PER_MIN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPRAY = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_scent;
  logic [PRE_W-1:0] r_presc;
  logic [PH_W-1:0]  r_phase;

  logic       w_run;
  logic       w_tick;
  logic       w_start_ok;
  logic       w_load;
  logic       w_expire;
  logic       w_phase_end;
  logic [1:0] w_scent_next;
  logic [6:0] w_timer_min;
  logic [2:0] w_pump_next;

  assign w_run      = (r_state == S_SPRAY) || (r_state == S_PAUSE);
  assign w_tick     = w_run && (r_presc == PRE_LAST);
  assign w_start_ok = start && (scent_sel != 2'd3) && (timer_sel != 2'd3);
  // stop outranks start everywhere; a start landing on the DONE cycle is dropped
  assign w_load     = w_start_ok && !stop && (r_state != S_DONE);
  assign w_expire   = w_tick && (remain_min == 7'd0) && (remain_sec == 6'd1);
  assign w_phase_end = w_tick &&
                       (((r_state == S_SPRAY) && (r_phase == SPRAY_LAST)) ||
                        ((r_state == S_PAUSE) && (r_phase == PAUSE_LAST)));
  assign w_scent_next = w_load ? scent_sel : r_scent;

  always_comb begin
    w_timer_min = 7'(TIMER0_MIN);
    case (timer_sel)
      2'd1:    w_timer_min = 7'(TIMER1_MIN);
      2'd2:    w_timer_min = 7'(TIMER2_MIN);
      default: w_timer_min = 7'(TIMER0_MIN);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load) w_state_next = S_SPRAY;
      end
      S_SPRAY, S_PAUSE: begin
        if (stop)             w_state_next = S_IDLE;
        else if (w_load)      w_state_next = S_SPRAY;
        else if (w_expire)    w_state_next = S_DONE;
        else if (w_phase_end) w_state_next = (r_state == S_SPRAY) ? S_PAUSE : S_SPRAY;
      end
      default: w_state_next = S_IDLE;
    endcase
    w_pump_next = 3'd0;
    if (w_state_next == S_SPRAY) w_pump_next = 3'd1 << w_scent_next;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scent    <= 2'd0;
      r_presc    <= '0;
      r_phase    <= '0;
      remain_min <= 7'd0;
      remain_sec <= 6'd0;
      pump_en    <= 3'd0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      pump_en <= w_pump_next;
      running <= (w_state_next == S_SPRAY) || (w_state_next == S_PAUSE);
      done    <= (w_state_next == S_DONE);
      if (w_load) begin
        r_scent    <= scent_sel;
        r_presc    <= '0;
        r_phase    <= '0;
        remain_min <= w_timer_min;
        remain_sec <= 6'd0;
      end else if (w_run) begin
        if (stop) begin
          r_presc <= '0;
          r_phase <= '0;
        end else if (w_tick) begin
          r_presc <= '0;
          r_phase <= w_phase_end ? '0 : r_phase + 1'b1;
          if (w_expire) begin
            remain_min <= 7'd0;
            remain_sec <= 6'd0;
          end else if (remain_sec == 6'd0) begin
            remain_min <= remain_min - 7'd1;
            remain_sec <= SEC_TOP;
          end else begin
            remain_sec <= remain_sec - 6'd1;
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_diffuser_scheduler.sv
// tb/tb_diffuser_scheduler.sv - directed checks of diffuser_scheduler on shrunk timing
module tb_diffuser_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] scent_sel = 2'd0;
  logic [1:0] timer_sel = 2'd0;
  logic [2:0] pump_en;
  logic       running;
  logic       done;
  logic [6:0] remain_min;
  logic [5:0] remain_sec;

  int n_total = 0;
  int n_bad   = 0;

  diffuser_scheduler #(
    .TICKS_PER_SEC(4),
    .SEC_PER_MIN  (3),
    .SPRAY_SEC    (2),
    .PAUSE_SEC    (3),
    .TIMER0_MIN   (1),
    .TIMER1_MIN   (2),
    .TIMER2_MIN   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .scent_sel (scent_sel),
    .timer_sel (timer_sel),
    .pump_en   (pump_en),
    .running   (running),
    .done      (done),
    .remain_min(remain_min),
    .remain_sec(remain_sec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] sc, input logic [1:0] tm);
    scent_sel = sc;
    timer_sel = tm;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // scent=1, timer=0 (1 minute); returns at cycle 14
  task automatic basic_run(input string pfx);
    launch(2'd1, 2'd0);
    chk({pfx, " c1 pump"}, pump_en, 3'b010);
    chk({pfx, " c1 running"}, running, 1);
    chk({pfx, " c1 min"}, remain_min, 1);
    chk({pfx, " c1 sec"}, remain_sec, 0);
    cyc(3);
    chk({pfx, " c4 sec"}, remain_sec, 0);
    cyc(1);
    chk({pfx, " c5 min"}, remain_min, 0);
    chk({pfx, " c5 sec"}, remain_sec, 2);
    cyc(3);
    chk({pfx, " c8 pump"}, pump_en, 3'b010);
    cyc(1);
    chk({pfx, " c9 sec"}, remain_sec, 1);
    chk({pfx, " c9 pump"}, pump_en, 3'b000);
    chk({pfx, " c9 running"}, running, 1);
    cyc(4);
    chk({pfx, " c13 done"}, done, 1);
    chk({pfx, " c13 running"}, running, 0);
    chk({pfx, " c13 min"}, remain_min, 0);
    chk({pfx, " c13 sec"}, remain_sec, 0);
    cyc(1);
    chk({pfx, " c14 done"}, done, 0);
    chk({pfx, " c14 running"}, running, 0);
  endtask

  initial begin
    int ons;
    int dones;
    int done_at;

    do_reset();
    chk("rst pump", pump_en, 0);
    chk("rst running", running, 0);
    chk("rst done", done, 0);
    chk("rst min", remain_min, 0);
    chk("rst sec", remain_sec, 0);

    basic_run("basic");

    // long run: 2 minutes, scent 2; selects change mid-run and must be ignored
    launch(2'd2, 2'd1);
    ons = 0;
    dones = 0;
    done_at = -1;
    for (int c = 1; c <= 27; c++) begin
      logic exp_on;
      exp_on = ((c >= 1) && (c <= 8)) || ((c >= 21) && (c <= 24));
      chk($sformatf("long c%0d pump", c), pump_en, exp_on ? 3'b100 : 3'b000);
      if (pump_en == 3'b100) ons++;
      if (done) begin
        dones++;
        done_at = c;
      end
      if (c == 1) chk("long c1 min", remain_min, 2);
      if (c == 5) begin
        chk("long c5 min", remain_min, 1);
        chk("long c5 sec", remain_sec, 2);
      end
      if (c == 17) begin
        chk("long c17 min", remain_min, 0);
        chk("long c17 sec", remain_sec, 2);
      end
      if (c == 3) begin
        scent_sel = 2'd0;
        timer_sel = 2'd3;
      end
      cyc(1);
    end
    chk("long on cycles", ons, 12);
    chk("long done count", dones, 1);
    chk("long done cycle", done_at, 25);

    // stop at cycle 6
    launch(2'd1, 2'd0);
    cyc(5);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop c7 pump", pump_en, 0);
    chk("stop c7 running", running, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      cyc(1);
    end
    chk("stop done count", dones, 0);
    chk("stop min held", remain_min, 0);
    chk("stop sec held", remain_sec, 2);

    // start+stop together mid-run
    launch(2'd1, 2'd0);
    cyc(5);
    scent_sel = 2'd0;
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    chk("both running", running, 0);
    chk("both pump", pump_en, 0);
    chk("both sec held", remain_sec, 2);
    cyc(5);
    chk("both stays idle", running, 0);

    // invalid selects in IDLE
    do_reset();
    launch(2'd3, 2'd0);
    chk("inv scent running", running, 0);
    chk("inv scent pump", pump_en, 0);
    chk("inv scent min", remain_min, 0);
    launch(2'd0, 2'd3);
    chk("inv timer running", running, 0);
    chk("inv timer min", remain_min, 0);
    cyc(3);
    chk("inv later running", running, 0);
    chk("inv later pump", pump_en, 0);

    // restart at cycle 6 with scent 0
    launch(2'd1, 2'd0);
    cyc(5);
    launch(2'd0, 2'd0);
    chk("rs c7 pump", pump_en, 3'b001);
    chk("rs c7 min", remain_min, 1);
    chk("rs c7 sec", remain_sec, 0);
    chk("rs c7 done", done, 0);
    cyc(3);
    chk("rs c10 sec", remain_sec, 0);
    cyc(1);
    chk("rs c11 min", remain_min, 0);
    chk("rs c11 sec", remain_sec, 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // reset mid-spray, then a normal run
    launch(2'd2, 2'd2);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mrst pump", pump_en, 0);
    chk("mrst running", running, 0);
    chk("mrst min", remain_min, 0);
    chk("mrst sec", remain_sec, 0);
    basic_run("after rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
